// File: rtl/gcd_stream_engine.sv
// Streaming GCD engine: subtractive GCD, one subtraction per clock, with
// valid/ready handshakes, a saturating iteration counter and 0/0 detection.
module gcd_stream_engine #(
  parameter int WIDTH  = 8,
  parameter int ITER_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  gcd_out,
  output logic [ITER_W-1:0] iter_count,
  output logic              zero_err,
  output logic              a_greater_b
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    a_q, b_q, a_nxt, b_nxt;
  logic [ITER_W-1:0]   cnt_q, cnt_nxt;
  logic [WIDTH-1:0]    gcd_nxt;
  logic [ITER_W-1:0]   iter_nxt;
  logic                zerr_nxt;
  logic                agb_nxt;
  logic                in_ready_nxt;
  logic                out_valid_nxt;

  // Counter holds at all-ones instead of wrapping.
  function automatic logic [ITER_W-1:0] sat_inc(input logic [ITER_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      gcd_out     <= '0;
      iter_count  <= '0;
      zero_err    <= 1'b0;
      a_greater_b <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
    end else begin
      state       <= state_nxt;
      a_q         <= a_nxt;
      b_q         <= b_nxt;
      cnt_q       <= cnt_nxt;
      gcd_out     <= gcd_nxt;
      iter_count  <= iter_nxt;
      zero_err    <= zerr_nxt;
      a_greater_b <= agb_nxt;
      in_ready    <= in_ready_nxt;
      out_valid   <= out_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    a_nxt         = a_q;
    b_nxt         = b_q;
    cnt_nxt       = cnt_q;
    gcd_nxt       = gcd_out;
    iter_nxt      = iter_count;
    zerr_nxt      = zero_err;
    agb_nxt       = a_greater_b;
    in_ready_nxt  = in_ready;
    out_valid_nxt = out_valid;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_nxt        = a_in;
          b_nxt        = b_in;
          cnt_nxt      = '0;
          zerr_nxt     = 1'b0;
          in_ready_nxt = 1'b0;
          state_nxt    = CALC;
        end
      end

      CALC: begin
        // Termination checks first; the larger operand is always the minuend.
        if (a_q == '0 && b_q == '0) begin
          gcd_nxt       = '0;
          zerr_nxt      = 1'b1;
          iter_nxt      = cnt_q;
          out_valid_nxt = 1'b1;
          state_nxt     = DONE;
        end else if (a_q == '0) begin
          gcd_nxt       = b_q;
          zerr_nxt      = 1'b0;
          iter_nxt      = cnt_q;
          out_valid_nxt = 1'b1;
          state_nxt     = DONE;
        end else if (b_q == '0 || a_q == b_q) begin
          gcd_nxt       = a_q;
          zerr_nxt      = 1'b0;
          iter_nxt      = cnt_q;
          out_valid_nxt = 1'b1;
          state_nxt     = DONE;
        end else if (a_q > b_q) begin
          a_nxt   = a_q - b_q;
          agb_nxt = 1'b1;
          cnt_nxt = sat_inc(cnt_q);
        end else begin
          b_nxt   = b_q - a_q;
          agb_nxt = 1'b0;
          cnt_nxt = sat_inc(cnt_q);
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          in_ready_nxt  = 1'b1;
          state_nxt     = IDLE;
        end
      end

      default: begin
        state_nxt     = IDLE;
        in_ready_nxt  = 1'b1;
        out_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_gcd_stream_engine.sv
// Bench for gcd_stream_engine: a 16-bit-counter and a 4-bit-counter instance
// share stimulus and are checked against a quotient-based Euclid model.
module tb_gcd_stream_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a_in, b_in;
  logic       out_ready;

  logic        in_ready,   out_valid,   zero_err,   a_greater_b;
  logic [7:0]  gcd_out;
  logic [15:0] iter_count;
  logic        in_ready_s, out_valid_s, zero_err_s, a_greater_b_s;
  logic [7:0]  gcd_out_s;
  logic [3:0]  iter_count_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gcd_stream_engine #(.WIDTH(8), .ITER_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .gcd_out(gcd_out), .iter_count(iter_count), .zero_err(zero_err),
    .a_greater_b(a_greater_b)
  );

  gcd_stream_engine #(.WIDTH(8), .ITER_W(4)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid_s), .out_ready(out_ready),
    .gcd_out(gcd_out_s), .iter_count(iter_count_s), .zero_err(zero_err_s),
    .a_greater_b(a_greater_b_s)
  );

  typedef struct {
    int a; int b; int g; int k; int z; int d; int hold;
  } vec_t;

  vec_t tbl[9];
  int   prev_dir = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},    int'(in_ready),    1);
    check({tag, "_out_valid"},   int'(out_valid),   0);
    check({tag, "_gcd"},         int'(gcd_out),     0);
    check({tag, "_iter"},        int'(iter_count),  0);
    check({tag, "_zerr"},        int'(zero_err),    0);
    check({tag, "_agb"},         int'(a_greater_b), 0);
    check({tag, "_s_gcd"},       int'(gcd_out_s),   0);
    check({tag, "_s_out_valid"}, int'(out_valid_s), 0);
  endtask

  // Reference: Euclid by quotients. Each run of q repeated subtractions of the
  // smaller operand is one division step; the count is the sum of those runs.
  task automatic model(input int a, input int b, input int dir_in,
                       output int g, output int k, output int z, output int d);
    int x, y, q;
    g = 0; k = 0; z = 0; d = dir_in;
    if (a == 0 && b == 0) begin
      z = 1;
    end else if (a == 0) begin
      g = b;
    end else if (b == 0) begin
      g = a;
    end else begin
      x = a; y = b;
      while (x != y) begin
        if (x > y) begin
          q = (x - 1) / y; x = x - q * y; k += q; d = 1;
        end else begin
          q = (y - 1) / x; y = y - q * x; k += q; d = 0;
        end
      end
      g = x;
    end
  endtask

  task automatic op(input int a, input int b, input int hold,
                    input int g, input int k, input int z, input int d);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_op", int'(in_ready), 1);
    in_valid = 1'b1; a_in = 8'(a); b_in = 8'(b);
    @(posedge clk); #1;
    // Junk operands with in_valid high during CALC must be ignored.
    a_in = 8'($urandom); b_in = 8'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 400);
    check("latency", lat, k + 1);
    check("gcd", int'(gcd_out), g);
    check("iter", int'(iter_count), (k > 65535) ? 65535 : k);
    check("zerr", int'(zero_err), z);
    check("agb", int'(a_greater_b), d);
    check("in_ready_busy", int'(in_ready), 0);
    check("s_out_valid", int'(out_valid_s), 1);
    check("s_gcd", int'(gcd_out_s), g);
    check("s_iter_sat", int'(iter_count_s), (k > 15) ? 15 : k);
    check("s_agb", int'(a_greater_b_s), d);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a_in = 8'($urandom); b_in = 8'($urandom);
      @(posedge clk); #1;
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_gcd", int'(gcd_out), g);
      check("hold_iter", int'(iter_count), k);
      check("hold_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_out_valid", int'(out_valid), 0);
    check("release_in_ready", int'(in_ready), 1);
    check("idle_gcd_held", int'(gcd_out), g);
    check("idle_zerr_held", int'(zero_err), z);
    prev_dir = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, k, z, d, a, b;
    bit saw_valid;

    tbl[0] = '{12,  8,   4, 2,   0, 0, 0};
    tbl[1] = '{255, 1,   1, 254, 0, 1, 0};
    tbl[2] = '{1,   255, 1, 254, 0, 0, 0};
    tbl[3] = '{0,   9,   9, 0,   0, 0, 0};
    tbl[4] = '{0,   0,   0, 0,   1, 0, 0};
    tbl[5] = '{6,   6,   6, 0,   0, 0, 0};
    tbl[6] = '{48,  18,  6, 4,   0, 1, 5};
    tbl[7] = '{9,   0,   9, 0,   0, 1, 0};
    tbl[8] = '{200, 1,   1, 199, 0, 1, 2};

    rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_values("reset");
    repeat (3) @(posedge clk);
    #1 check_reset_values("idle");

    for (int i = 0; i < 9; i++)
      op(tbl[i].a, tbl[i].b, tbl[i].hold, tbl[i].g, tbl[i].k, tbl[i].z, tbl[i].d);

    for (int i = 0; i < 30; i++) begin
      a = (i % 7 == 3) ? 0 : int'($urandom_range(1, 255));
      b = (i % 11 == 5) ? 0 : int'($urandom_range(1, 255));
      model(a, b, prev_dir, g, k, z, d);
      op(a, b, int'($urandom_range(0, 2)), g, k, z, d);
    end

    // Reset in the middle of a long computation.
    @(posedge clk); #1;
    in_valid = 1'b1; a_in = 8'd255; b_in = 8'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values("midcalc_reset");
    @(posedge clk); #1 rst = 1'b0;
    prev_dir = 0;
    saw_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (out_valid || out_valid_s) saw_valid = 1'b1;
    end
    check("no_result_after_reset", int'(saw_valid), 0);

    model(12, 8, prev_dir, g, k, z, d);
    op(12, 8, 1, g, k, z, d);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
